riscv_instr_decoder: RTL and testbench

Single-stage RV32I decode stage that consumes the sequential (pc, instruction) stream produced by the command-streaming fetch stage and presents decoded fields (register indices, function codes, sign-extended immediate, format class) to the downstream execute/trace logic. It uses a registered valid/ready handshake, halts the stream on ECALL/EBREAK/illegal encodings, and keeps accepted-instruction and illegal-instruction counters for simulation bring-up.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/riscv_imm_gen.sv | 25 ++
 rtl/riscv_instr_decoder.sv | 163 ++++++++++++++++
 tb/tb_riscv_instr_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, format classes,
// system instruction words and decode-stage state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] ECALL_W  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_W = 32'h0010_0073;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate extraction for the RV32I formats.
// R and NONE formats carry no immediate and yield zero.
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_instr_decoder.sv
// RV32I decode stage: registered valid/ready pipeline slot that halts
// on ECALL/EBREAK/illegal words and keeps saturating statistics.
module riscv_instr_decoder
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic             out_sys,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] illegal_count
);

    state_e      state;
    logic        accept;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    fmt_e        d_fmt;
    logic        d_legal;
    logic        d_sys;
    logic [2:0]  fmt_eff;
    logic [31:0] imm;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    assign halted   = (state == ST_HALTED);
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        d_fmt   = FMT_NONE;
        d_legal = 1'b0;
        d_sys   = 1'b0;
        unique case (opc)
            OP_LUI, OP_AUIPC: begin
                d_fmt   = FMT_U;
                d_legal = 1'b1;
            end
            OP_JAL: begin
                d_fmt   = FMT_J;
                d_legal = 1'b1;
            end
            OP_JALR: begin
                d_fmt   = FMT_I;
                d_legal = (f3 == 3'b000);
            end
            OP_BRANCH: begin
                d_fmt   = FMT_B;
                d_legal = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OP_LOAD: begin
                d_fmt   = FMT_I;
                d_legal = f3 inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101};
            end
            OP_STORE: begin
                d_fmt   = FMT_S;
                d_legal = (f3 <= 3'b010);
            end
            OP_IMM: begin
                d_fmt = FMT_I;
                // shift-immediates reuse funct7 as an encoding field
                if (f3 == 3'b001)
                    d_legal = (f7 == F7_BASE);
                else if (f3 == 3'b101)
                    d_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    d_legal = 1'b1;
            end
            OP_OP: begin
                d_fmt   = FMT_R;
                d_legal = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) &&
                           ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OP_MISC: begin
                d_fmt   = FMT_I;
                d_legal = 1'b1;
            end
            OP_SYSTEM: begin
                d_fmt   = FMT_I;
                d_sys   = (in_instr == ECALL_W) || (in_instr == EBREAK_W);
                d_legal = d_sys;
            end
            default: ;
        endcase
    end

    assign fmt_eff = d_legal ? d_fmt : FMT_NONE;

    riscv_imm_gen u_imm (
        .instr (in_instr),
        .fmt   (fmt_eff),
        .imm   (imm)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RUN;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_instr     <= '0;
            out_opcode    <= '0;
            out_rd        <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_funct3    <= '0;
            out_funct7    <= '0;
            out_imm       <= '0;
            out_fmt       <= '0;
            out_illegal   <= 1'b0;
            out_sys       <= 1'b0;
            instr_count   <= '0;
            illegal_count <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_instr   <= in_instr;
            out_opcode  <= opc;
            out_rd      <= in_instr[11:7];
            out_rs1     <= in_instr[19:15];
            out_rs2     <= in_instr[24:20];
            out_funct3  <= f3;
            out_funct7  <= f7;
            out_imm     <= imm;
            out_fmt     <= fmt_eff;
            out_illegal <= !d_legal;
            out_sys     <= d_sys;
            if (instr_count != '1)
                instr_count <= instr_count + CNT_W'(1);
            if (!d_legal && (illegal_count != '1))
                illegal_count <= illegal_count + CNT_W'(1);
            if (!d_legal || d_sys)
                state <= ST_HALTED;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_instr_decoder.sv
// Directed and randomized checks of the decode stage against a
// cycle-level reference model built from the instruction-set rules.
module tb_riscv_instr_decoder;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [6:0]    out_opcode;
    logic [4:0]    out_rd;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rs2;
    logic [2:0]    out_funct3;
    logic [6:0]    out_funct7;
    logic [31:0]   out_imm;
    logic [2:0]    out_fmt;
    logic          out_illegal;
    logic          out_sys;
    logic          halted;
    logic [CW-1:0] instr_count;
    logic [CW-1:0] illegal_count;

    riscv_instr_decoder #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_opcode    (out_opcode),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct3    (out_funct3),
        .out_funct7    (out_funct7),
        .out_imm       (out_imm),
        .out_fmt       (out_fmt),
        .out_illegal   (out_illegal),
        .out_sys       (out_sys),
        .halted        (halted),
        .instr_count   (instr_count),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic         m_halted;
    logic         m_ov;
    logic [132:0] m_rec;
    int           m_ic;
    int           m_lc;
    int           pc_next;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint fld(input logic [31:0] w, input int hi,
                                   input int lo);
        return longint'((w >> lo) & ((64'd1 << (hi - lo + 1)) - 1));
    endfunction

    function automatic void ref_dec(input logic [31:0] w,
                                    output int fmt, output logic [31:0] imm,
                                    output logic ill, output logic sys);
        longint op, f3, f7, v;
        op  = fld(w, 6, 0);
        f3  = fld(w, 14, 12);
        f7  = fld(w, 31, 25);
        ill = 1'b0;
        sys = 1'b0;
        fmt = 6;
        case (op)
            'h37, 'h17: fmt = 4;
            'h6F: fmt = 5;
            'h67: begin fmt = 1; ill = (f3 != 0); end
            'h63: begin fmt = 3; ill = (f3 == 2 || f3 == 3); end
            'h03: begin fmt = 1; ill = !(f3 inside {0, 1, 2, 4, 5}); end
            'h23: begin fmt = 2; ill = (f3 > 2); end
            'h13: begin
                fmt = 1;
                ill = (f3 == 1 && f7 != 0) ||
                      (f3 == 5 && !(f7 inside {0, 32}));
            end
            'h33: begin
                fmt = 0;
                ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            end
            'h0F: fmt = 1;
            'h73: begin
                fmt = 1;
                sys = (w == 32'h73) || (w == 32'h0010_0073);
                ill = !sys;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            fmt = 6;
            sys = 1'b0;
        end
        v = 0;
        case (fmt)
            1: begin
                v = fld(w, 31, 20);
                if (v >= 2048) v -= 4096;
            end
            2: begin
                v = fld(w, 31, 25) * 32 + fld(w, 11, 7);
                if (v >= 2048) v -= 4096;
            end
            3: begin
                v = fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048 +
                    fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2;
                if (v >= 4096) v -= 8192;
            end
            4: v = fld(w, 31, 12) * 4096;
            5: begin
                v = fld(w, 31, 31) * (1 << 20) + fld(w, 19, 12) * 4096 +
                    fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            default: v = 0;
        endcase
        imm = v[31:0];
    endfunction

    function automatic logic [132:0] build(input logic [31:0] pc,
                                           input logic [31:0] w);
        int          f;
        logic [31:0] im;
        logic        il, sy;
        logic [2:0]  f3b;
        ref_dec(w, f, im, il, sy);
        f3b = f[2:0];
        return {pc, w, w[6:0], w[11:7], w[19:15], w[24:20], w[14:12],
                w[31:25], im, f3b, il, sy};
    endfunction

    // one clock: drive inputs, check in_ready, advance model, check outputs
    task automatic cycle(input logic v, input logic [31:0] pc,
                         input logic [31:0] w, input logic ordy,
                         input logic rst);
        logic exp_rdy;
        logic [132:0] obs;
        int f;
        logic [31:0] im;
        logic il, sy;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = w;
        out_ready = ordy;
        reset     = rst;
        #1;
        exp_rdy = !m_halted && (!m_ov || ordy);
        chk("in_ready", 256'(in_ready), 256'(exp_rdy));
        if (rst) begin
            m_halted = 1'b0;
            m_ov     = 1'b0;
            m_rec    = '0;
            m_ic     = 0;
            m_lc     = 0;
        end else if (v && exp_rdy) begin
            ref_dec(w, f, im, il, sy);
            m_rec = build(pc, w);
            m_ov  = 1'b1;
            m_ic  = (m_ic < CMAX) ? m_ic + 1 : CMAX;
            if (il) m_lc = (m_lc < CMAX) ? m_lc + 1 : CMAX;
            if (il || sy) m_halted = 1'b1;
            pc_next += 4;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        obs = {out_pc, out_instr, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_fmt, out_illegal,
               out_sys};
        chk("out_valid", 256'(out_valid), 256'(m_ov));
        chk("halted", 256'(halted), 256'(m_halted));
        chk("instr_count", 256'(instr_count), 256'(m_ic));
        chk("illegal_count", 256'(illegal_count), 256'(m_lc));
        chk("record", 256'(obs), 256'(m_rec));
    endtask

    task automatic feed(input logic [31:0] w, input logic ordy);
        cycle(1'b1, 32'(pc_next), w, ordy, 1'b0);
    endtask

    function automatic logic [31:0] gen();
        logic [6:0]  ops [11];
        logic [31:0] w;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h0F, 7'h13, 7'h33, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k <= 10) begin
            w[6:0] = ops[k];
            if (k >= 8 && k <= 9)
                w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end else if (k == 11) begin
            w = 32'h0000_0073;
        end else if (k == 12) begin
            w = 32'h0010_0073;
        end
        return w;
    endfunction

    initial begin
        m_halted  = 1'b0;
        m_ov      = 1'b0;
        m_rec     = '0;
        m_ic      = 0;
        m_lc      = 0;
        pc_next   = 0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_imm", 256'(out_imm), 256'(0));

        // ADDI x1, x0, 5
        feed(32'h0050_0093, 1'b1);
        chk("addi_fmt", 256'(out_fmt), 256'(1));
        chk("addi_rd", 256'(out_rd), 256'(1));
        chk("addi_imm", 256'(out_imm), 256'(5));
        chk("addi_cnt", 256'(instr_count), 256'(1));

        feed(32'hFE00_0EE3, 1'b1);
        chk("b_imm", 256'(out_imm), 256'(32'hFFFF_FFFC));
        chk("b_fmt", 256'(out_fmt), 256'(3));
        feed(32'h1234_52B7, 1'b1);
        chk("u_imm", 256'(out_imm), 256'(32'h1234_5000));
        chk("u_rd", 256'(out_rd), 256'(5));
        feed(32'h0080_00EF, 1'b1);
        chk("j_imm", 256'(out_imm), 256'(8));
        chk("j_rd", 256'(out_rd), 256'(1));
        chk("stream_cnt", 256'(instr_count), 256'(4));

        // backpressure: the presented word waits until release
        feed(32'h0000_0013, 1'b0);
        chk("bp_ready", 256'(in_ready), 256'(0));
        feed(32'h0000_0013, 1'b0);
        feed(32'h0000_0013, 1'b0);
        chk("bp_cnt", 256'(instr_count), 256'(4));
        chk("bp_hold", 256'(out_instr), 256'(32'h0080_00EF));
        feed(32'h0000_0013, 1'b1);
        chk("bp_resume", 256'(out_instr), 256'(32'h0000_0013));
        chk("bp_cnt2", 256'(instr_count), 256'(5));

        // illegal word halts; following word never accepted
        feed(32'h0000_0000, 1'b1);
        chk("ill_flag", 256'(out_illegal), 256'(1));
        chk("ill_fmt", 256'(out_fmt), 256'(6));
        chk("ill_halt", 256'(halted), 256'(1));
        chk("ill_cnt", 256'(illegal_count), 256'(1));
        feed(32'h0050_0093, 1'b1);
        feed(32'h0050_0093, 1'b1);
        chk("ill_blocked", 256'(instr_count), 256'(6));

        // ECALL halts, reset recovers
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        pc_next = 0;
        feed(32'h0000_0073, 1'b0);
        chk("ecall_sys", 256'(out_sys), 256'(1));
        chk("ecall_halt", 256'(halted), 256'(1));
        cycle(1'b1, 0, 32'h0050_0093, 1'b0, 1'b1);
        chk("rst_halt", 256'(halted), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_cnt", 256'(instr_count), 256'(0));
        pc_next = 0;
        feed(32'h4000_5013, 1'b1);
        chk("srai_legal", 256'(out_illegal), 256'(0));
        feed(32'h0200_0033, 1'b1);
        chk("mul_illegal", 256'(out_illegal), 256'(1));

        // counter saturation
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < CMAX + 4; i++)
            feed(32'h0010_0093, 1'b1);
        chk("sat_cnt", 256'(instr_count), 256'(CMAX));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_halted && !m_ov) || $urandom_range(0, 99) == 0)
                cycle(1'($urandom_range(0, 1)), 32'(pc_next), gen(),
                      1'($urandom_range(0, 1)), 1'b1);
            else
                cycle(1'($urandom_range(0, 3) != 0), 32'(pc_next), gen(),
                      1'($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
